vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 130 +++++++++++++
 tb/tb_vram_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter, video reads over a buffered CPU port
//
// Shares one synchronous SRAM between a video controller and a CPU.
// Video reads always win.
// A CPU request is held in a one-entry buffer until a cycle without a video read.
//
// Parameters:
//   ADDR_W, DATA_W   address / data width
// Ports:
//   clk_pixel, reset                   clock, synchronous active-high reset
//   vid_addr, vid_rd, vid_data         video read port (data one cycle after vid_rd)
//   cpu_addr, cpu_wdata, cpu_rd,
//   cpu_wr, cpu_busy, cpu_ack,
//   cpu_rdata                          CPU request / completion port
//   mem_addr, mem_wdata, mem_we,
//   mem_rdata                          synchronous SRAM (read data one cycle late)
//   stall_count                        video-stall cycle counter, present only
//                                      when VRAM_ARB_STALL_STATS_EN is defined
module vram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_rd,
    output logic [DATA_W-1:0] vid_data,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic              cpu_busy,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
`ifdef VRAM_ARB_STALL_STATS_EN
    output logic [15:0]       stall_count,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state, next_state;
    logic              accept, issue;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_wr;
    logic              vid_pend;
    logic [DATA_W-1:0] vid_hold;
    logic [DATA_W-1:0] rdata_q;
    logic              done_rd;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state    <= S_IDLE;
            buf_addr <= '0;
            buf_data <= '0;
            buf_wr   <= 1'b0;
            vid_pend <= 1'b0;
            vid_hold <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= next_state;
            vid_pend <= vid_rd;
            if (vid_pend)
                vid_hold <= mem_rdata;
            // Uses the kind of the request that is completing, before a new
            // request accepted in this same DONE cycle overwrites the buffer.
            if (done_rd)
                rdata_q <= mem_rdata;
            if (accept) begin
                buf_addr <= cpu_addr;
                buf_data <= cpu_wdata;
                buf_wr   <= cpu_wr;     // a simultaneous rd+wr is a write
            end
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (cpu_rd || cpu_wr) begin
                    accept     = 1'b1;
                    next_state = S_WAIT;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                // Video holds the SRAM; the buffered request waits, never dropped.
                if (!vid_rd) begin
                    issue      = 1'b1;
                    next_state = S_DONE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign done_rd = (state == S_DONE) && !buf_wr;

    // Reset gates the status outputs combinationally.
    // A request caught mid-flight by reset never shows busy, ack or a write.
    assign cpu_busy  = (state == S_WAIT) && !reset;
    assign cpu_ack   = (state == S_DONE) && !reset;
    assign mem_we    = issue && buf_wr && !reset;
    assign mem_addr  = issue ? buf_addr : vid_addr;
    assign mem_wdata = buf_data;

    // SRAM data arrives one cycle after its address.
    // Pass it straight through in that cycle, otherwise show the held copy.
    assign vid_data  = vid_pend ? mem_rdata : vid_hold;
    assign cpu_rdata = reset ? '0 : (done_rd ? mem_rdata : rdata_q);

`ifdef VRAM_ARB_STALL_STATS_EN
    always_ff @(posedge clk_pixel) begin
        if (reset)
            stall_count <= 16'h0000;
        else if ((state == S_WAIT) && vid_rd && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with an SRAM model
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] vid_addr, cpu_addr, mem_addr;
    logic        vid_rd, cpu_rd, cpu_wr, cpu_busy, cpu_ack, mem_we;
    logic [7:0]  vid_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
`ifdef VRAM_ARB_STALL_STATS_EN
    logic [15:0] stall_count;
`endif

    vram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk_pixel(clk), .reset(reset),
        .vid_addr(vid_addr), .vid_rd(vid_rd), .vid_data(vid_data),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
`ifdef VRAM_ARB_STALL_STATS_EN
        .stall_count(stall_count),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_rd;
        logic [7:0] data;
    } exp_t;

    exp_t        cpu_q[$];
    logic [7:0]  vid_q[$];
    logic [15:0] wlog[$];
    logic [7:0]  mem [0:65535];
    bit          vid_seen = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          busy_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Synchronous SRAM model, plus a log of every write address.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wlog.push_back(mem_addr);
        end
        mem_rdata <= mem[mem_addr];
        vid_seen  <= vid_rd;
    end

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
        if (vid_seen) begin
            if (vid_q.size() == 0) chk("vid_unexpected", 1, 0);
            else chk("vid_data", {24'h0, vid_data}, {24'h0, vid_q.pop_front()});
        end
        if (cpu_ack) begin
            if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 1, 0);
            else begin
                exp_t e;
                e = cpu_q.pop_front();
                if (e.is_rd) chk("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_rd = 0; cpu_wr = 0; vid_rd = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'h0010] = 8'h3C;
        mem[16'h2000] = 8'h01; mem[16'h2001] = 8'h02; mem[16'h2002] = 8'h03;
        mem[16'h2003] = 8'h04; mem[16'h2004] = 8'h05; mem[16'h2005] = 8'h06;
        reset = 1; vid_addr = 0; cpu_addr = 0; cpu_wdata = 0;
        idle_inputs();
        tick(); tick();
        at_neg();
        chk("rst_busy", cpu_busy, 0);
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_vid_data", vid_data, 0);
        tick();
        reset = 0;
        tick();

        // Video read: address goes straight to the SRAM, data a cycle later.
        vid_rd = 1; vid_addr = 16'h1234; vid_q.push_back(8'hA5);
        at_neg();
        chk("vid_mem_addr", mem_addr, 16'h1234);
        chk("vid_mem_we", mem_we, 0);
        tick(); vid_rd = 0;
        at_neg();
        tick();
        at_neg();
        chk("vid_data_held", vid_data, 8'hA5);
        tick();

        // Write 0x5A to 0x0040, then back-to-back read of the same address.
        cpu_wr = 1; cpu_addr = 16'h0040; cpu_wdata = 8'h5A;
        cpu_q.push_back('{is_rd: 0, data: 8'h00});
        tick(); cpu_wr = 0;
        at_neg();
        chk("wr_we_t1", mem_we, 1);
        chk("wr_addr_t1", mem_addr, 16'h0040);
        chk("wr_wdata_t1", mem_wdata, 8'h5A);
        chk("wr_busy_t1", cpu_busy, 1);
        tick();
        cpu_rd = 1; cpu_addr = 16'h0040;
        cpu_q.push_back('{is_rd: 1, data: 8'h5A});
        at_neg();
        chk("wr_ack_t2", cpu_ack, 1);
        tick(); cpu_rd = 0;
        at_neg();
        chk("rd_we_t1", mem_we, 0);
        tick(); tick();
        at_neg();
        chk("rd_rdata_held", cpu_rdata, 8'h5A);
        chk("rd_ack_done", cpu_ack, 0);

        // A CPU read stalls behind five cycles of video reads.
        tick();
        cpu_rd = 1; cpu_addr = 16'h0010;
        cpu_q.push_back('{is_rd: 1, data: 8'h3C});
        busy_cycles = 0;
        tick(); cpu_rd = 0;
        for (int i = 0; i < 5; i++) begin
            vid_rd = 1; vid_addr = 16'h2000 + 16'(i); vid_q.push_back(8'(i + 1));
            at_neg();
            if (cpu_busy) busy_cycles++;
            chk("stall_we", mem_we, 0);
            chk("stall_vid_addr", mem_addr, 16'h2000 + 16'(i));
            tick();
        end
        vid_rd = 0;
        at_neg();
        if (cpu_busy) busy_cycles++;
        chk("stall_issue_addr", mem_addr, 16'h0010);
        chk("stall_issue_we", mem_we, 0);
        tick();
        at_neg();
        chk("stall_ack", cpu_ack, 1);
        chk("stall_busy_after", cpu_busy, 0);
        chk("stall_busy_cycles", busy_cycles, 6);
`ifdef VRAM_ARB_STALL_STATS_EN
        chk("stall_count", stall_count, 5);
`endif
        tick();

        // A second write while busy is ignored.
        wlog.delete();
        cpu_wr = 1; cpu_addr = 16'h0100; cpu_wdata = 8'h77;
        cpu_q.push_back('{is_rd: 0, data: 8'h00});
        tick();
        cpu_addr = 16'h0200; cpu_wdata = 8'h88;
        tick(); cpu_wr = 0;
        tick(); tick();
        chk("ign_wlog_size", wlog.size(), 1);
        if (wlog.size() > 0) chk("ign_wlog_addr", wlog[0], 16'h0100);
        chk("ign_mem_0100", mem[16'h0100], 8'h77);
        chk("ign_mem_0200", mem[16'h0200], 8'h00);

        // rd+wr together count as a write.
        cpu_rd = 1; cpu_wr = 1; cpu_addr = 16'h0001; cpu_wdata = 8'hFF;
        cpu_q.push_back('{is_rd: 0, data: 8'h00});
        tick(); idle_inputs();
        at_neg();
        chk("both_we", mem_we, 1);
        chk("both_addr", mem_addr, 16'h0001);
        chk("both_wdata", mem_wdata, 8'hFF);
        tick(); tick();
        cpu_rd = 1; cpu_addr = 16'h0001;
        cpu_q.push_back('{is_rd: 1, data: 8'hFF});
        tick(); cpu_rd = 0;
        tick(); tick(); tick();

        // Reset while the request waits: no ack and no write.
        wlog.delete();
        cpu_wr = 1; cpu_addr = 16'h0300; cpu_wdata = 8'h99;
        tick(); cpu_wr = 0;
        vid_rd = 1; vid_addr = 16'h1234; vid_q.push_back(8'hA5);
        tick();
        vid_rd = 0; reset = 1;
        at_neg();
        chk("rstw_we", mem_we, 0);
        chk("rstw_busy_now", cpu_busy, 0);
        tick(); reset = 0;
        at_neg();
        chk("rstw_busy", cpu_busy, 0);
        chk("rstw_ack", cpu_ack, 0);
`ifdef VRAM_ARB_STALL_STATS_EN
        chk("rstw_stall_count", stall_count, 0);
`endif
        tick(); tick(); tick();
        chk("rstw_wlog", wlog.size(), 0);
        chk("rstw_mem_0300", mem[16'h0300], 8'h00);
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("vid_q_empty", vid_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
